// File: rtl/camera_view_controller_if.sv
// Signal bundle between the board/sync-generator side and the camera view controller.
interface camera_view_controller_if;
  logic       enable;
  logic       btn_left;
  logic       btn_right;
  logic [9:0] vCount;
  logic [2:0] camera_view;
  logic       view_stable;
  logic       view_changed;

  modport master (
    output enable, btn_left, btn_right, vCount,
    input  camera_view, view_stable, view_changed
  );

  modport slave (
    input  enable, btn_left, btn_right, vCount,
    output camera_view, view_stable, view_changed
  );
endinterface

// File: rtl/camera_view_controller.sv
// Debounced left/right buttons drive a camera view state machine whose
// transitions are committed only at the first cycle of vertical blank.
module camera_view_controller #(
  parameter int DB_CYCLES     = 250000,
  parameter int TRANS_FRAMES  = 8,
  parameter int VIS_LAST_LINE = 515
) (
  input  logic                       clk,
  input  logic                       reset,
  camera_view_controller_if.slave    cv
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int FC_W = $clog2(TRANS_FRAMES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TRANS_FRAMES - 1);

  typedef enum logic [2:0] {
    V_ILLEGAL = 3'b000,
    V_FWD     = 3'b001,
    V_F2L     = 3'b010,
    V_LEFT    = 3'b011,
    V_L2F     = 3'b100,
    V_F2R     = 3'b101,
    V_RIGHT   = 3'b110,
    V_R2F     = 3'b111
  } view_t;

  logic [1:0] btn_raw;
  logic [1:0] btn_rise;

  assign btn_raw = {cv.btn_right, cv.btn_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic            level_d_reg;
      logic [DB_W-1:0] cnt_reg;

      // Counter only advances while the synced input disagrees with the level,
      // so it is bounded by DB_LAST and cannot wrap.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          sync1_reg   <= btn_raw[gi];
          sync2_reg   <= sync1_reg;
          level_d_reg <= level_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign btn_rise[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  logic in_blank;
  logic vblank_d_reg;
  logic frame_tick;

  assign in_blank   = (cv.vCount > 10'(VIS_LAST_LINE));
  assign frame_tick = in_blank & ~vblank_d_reg;

  view_t           view_reg, view_next;
  logic            pend_l_reg, pend_l_next;
  logic            pend_r_reg, pend_r_next;
  logic [FC_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic            view_stable_reg;
  logic            view_changed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_d_reg     <= 1'b0;
      view_reg         <= V_FWD;
      pend_l_reg       <= 1'b0;
      pend_r_reg       <= 1'b0;
      frame_cnt_reg    <= '0;
      view_stable_reg  <= 1'b1;
      view_changed_reg <= 1'b0;
    end else begin
      vblank_d_reg     <= in_blank;
      view_reg         <= view_next;
      pend_l_reg       <= pend_l_next;
      pend_r_reg       <= pend_r_next;
      frame_cnt_reg    <= frame_cnt_next;
      view_stable_reg  <= (view_next == V_FWD) || (view_next == V_LEFT) || (view_next == V_RIGHT);
      view_changed_reg <= (view_next != view_reg);
    end
  end

  always_comb begin
    view_next      = view_reg;
    pend_l_next    = pend_l_reg;
    pend_r_next    = pend_r_reg;
    frame_cnt_next = frame_cnt_reg;
    if (!cv.enable) begin
      view_next      = V_FWD;
      pend_l_next    = 1'b0;
      pend_r_next    = 1'b0;
      frame_cnt_next = '0;
    end else begin
      case (view_reg)
        V_FWD: if (frame_tick) begin
          if (pend_l_reg && pend_r_reg) begin
            pend_l_next = 1'b0;
            pend_r_next = 1'b0;
          end else if (pend_l_reg) begin
            view_next      = V_F2L;
            pend_l_next    = 1'b0;
            frame_cnt_next = '0;
          end else if (pend_r_reg) begin
            view_next      = V_F2R;
            pend_r_next    = 1'b0;
            frame_cnt_next = '0;
          end
        end
        V_LEFT: if (frame_tick) begin
          pend_l_next = 1'b0;
          if (pend_r_reg) begin
            view_next      = V_L2F;
            pend_r_next    = 1'b0;
            frame_cnt_next = '0;
          end
        end
        V_RIGHT: if (frame_tick) begin
          pend_r_next = 1'b0;
          if (pend_l_reg) begin
            view_next      = V_R2F;
            pend_l_next    = 1'b0;
            frame_cnt_next = '0;
          end
        end
        V_F2L, V_L2F, V_F2R, V_R2F: if (frame_tick) begin
          if (frame_cnt_reg == FC_LAST) begin
            case (view_reg)
              V_F2L:   view_next = V_LEFT;
              V_F2R:   view_next = V_RIGHT;
              default: view_next = V_FWD;
            endcase
          end else begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
          end
        end
        default: view_next = V_FWD;
      endcase
      // A request arriving on a tick cycle survives to the following tick.
      pend_l_next = pend_l_next | btn_rise[0];
      pend_r_next = pend_r_next | btn_rise[1];
    end
  end

  assign cv.camera_view  = view_reg;
  assign cv.view_stable  = view_stable_reg;
  assign cv.view_changed = view_changed_reg;

endmodule

// File: tb/tb_camera_view_controller.sv
// Randomized and directed checks of camera_view_controller against a behavioural view model.
module tb_camera_view_controller;
  localparam int DB     = 4;
  localparam int TRANS  = 2;
  localparam int VIS    = 515;
  localparam int FLEN   = 20;
  localparam int VISLEN = 14;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failures = 0;
  bit   run_cmp = 1'b0;

  camera_view_controller_if vif ();

  camera_view_controller #(.DB_CYCLES(DB), .TRANS_FRAMES(TRANS), .VIS_LAST_LINE(VIS)) dut (
    .clk   (clk),
    .reset (reset),
    .cv    (vif.slave)
  );

  always #5 clk = ~clk;

  // Short synthetic frame: VISLEN visible lines followed by blank lines above VIS.
  int fc = 0;
  initial begin
    vif.vCount = 10'd0;
    forever begin
      @(negedge clk);
      fc = (fc + 1) % FLEN;
      vif.vCount = (fc < VISLEN) ? 10'(fc) : 10'(VIS + 1 + fc - VISLEN);
    end
  end

  // Behavioural model: raw sample history, window-based debounce, view as rest/transition.
  logic [1:0] raw_q[$];
  logic [1:0] m_lvl, m_lvl_prev, m_pend;
  bit         m_prev_blank;
  int         m_rest;        // 0 forward, 1 left, 2 right
  bit         m_trans;
  int         m_dest;
  int         m_frames_left;
  logic [2:0] m_tcode;
  logic [2:0] m_view;
  bit         m_changed, m_stable;

  function automatic logic [2:0] model_code();
    if (m_trans) return m_tcode;
    case (m_rest)
      1:       return 3'b011;
      2:       return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  task automatic model_reset();
    raw_q = {};
    for (int i = 0; i < DB + 2; i++) raw_q.push_back(2'b00);
    m_lvl = 0; m_lvl_prev = 0; m_pend = 0; m_prev_blank = 0;
    m_rest = 0; m_trans = 0; m_dest = 0; m_frames_left = 0; m_tcode = 3'b001;
    m_view = 3'b001; m_changed = 0; m_stable = 1;
  endtask

  task automatic start_trans(input logic [2:0] code, input int dest);
    m_trans = 1; m_tcode = code; m_dest = dest; m_frames_left = TRANS;
  endtask

  task automatic model_step();
    logic [1:0] rise, new_lvl;
    logic [2:0] old_code;
    bit tick, blank;
    raw_q.push_front({vif.btn_right, vif.btn_left});
    raw_q.delete(raw_q.size() - 1);
    blank = (vif.vCount > VIS);
    tick = blank && !m_prev_blank;
    m_prev_blank = blank;
    rise = m_lvl & ~m_lvl_prev;
    new_lvl = m_lvl;
    for (int b = 0; b < 2; b++) begin
      bit all_diff = 1;
      for (int i = 2; i < DB + 2; i++) if (raw_q[i][b] == m_lvl[b]) all_diff = 0;
      if (all_diff) new_lvl[b] = ~m_lvl[b];
    end
    m_lvl_prev = m_lvl;
    m_lvl = new_lvl;
    old_code = model_code();
    if (!vif.enable) begin
      m_rest = 0; m_trans = 0; m_pend = 0;
    end else begin
      if (tick) begin
        if (m_trans) begin
          m_frames_left--;
          if (m_frames_left == 0) begin m_trans = 0; m_rest = m_dest; end
        end else if (m_rest == 0) begin
          if (m_pend == 2'b11) m_pend = 0;
          else if (m_pend[0]) begin start_trans(3'b010, 1); m_pend[0] = 0; end
          else if (m_pend[1]) begin start_trans(3'b101, 2); m_pend[1] = 0; end
        end else if (m_rest == 1) begin
          if (m_pend[1]) start_trans(3'b100, 0);
          m_pend = 0;
        end else begin
          if (m_pend[0]) start_trans(3'b111, 0);
          m_pend = 0;
        end
      end
      m_pend = m_pend | rise;
    end
    m_view = model_code();
    m_changed = (m_view != old_code);
    m_stable = !m_trans;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (run_cmp && !reset) begin
      tests++;
      if (vif.camera_view != m_view || vif.view_changed != m_changed || vif.view_stable != m_stable) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t: view=%b chg=%b stable=%b, expected view=%b chg=%b stable=%b",
                 $time, vif.camera_view, vif.view_changed, vif.view_stable, m_view, m_changed, m_stable);
      end
    end
  end

  task automatic check_lit(input string name, input logic [2:0] view, input logic chg, input logic stb);
    tests++;
    if (vif.camera_view != view || vif.view_changed != chg || vif.view_stable != stb) begin
      failures++;
      $display("FAIL %s: view=%b chg=%b stable=%b, expected view=%b chg=%b stable=%b",
               name, vif.camera_view, vif.view_changed, vif.view_stable, view, chg, stb);
    end
  endtask

  task automatic press(input logic l, input logic r, input int cycles);
    @(negedge clk);
    vif.btn_left = l; vif.btn_right = r;
    repeat (cycles) @(negedge clk);
    vif.btn_left = 0; vif.btn_right = 0;
  endtask

  // Waits (bounded) for a view_changed pulse and checks the new view against a literal.
  task automatic wait_change(input string name, input logic [2:0] exp, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!vif.view_changed && n < 200);
    tests++;
    if (!vif.view_changed || vif.camera_view != exp || m_view != exp) begin
      failures++;
      $display("FAIL %s: view=%b chg=%b model=%b after %0d cycles, expected view=%b",
               name, vif.camera_view, vif.view_changed, m_view, n, exp);
    end
  endtask

  initial begin
    int n;
    vif.enable = 1; vif.btn_left = 0; vif.btn_right = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check_lit("reset_state", 3'b001, 1'b0, 1'b1);
    run_cmp = 1;
    repeat (10) @(negedge clk);
    check_lit("idle_10", 3'b001, 1'b0, 1'b1);

    // Bounce: toggle every 2 cycles, never stable for DB cycles.
    for (int i = 0; i < 10; i++) begin
      vif.btn_left = ~vif.btn_left;
      repeat (2) @(negedge clk);
    end
    vif.btn_left = 0;
    repeat (3 * FLEN) @(negedge clk);
    check_lit("bounce_reject", 3'b001, 1'b0, 1'b1);

    // Left round trip.
    press(1, 0, 8);
    wait_change("to_ftol", 3'b010, n);
    tests++;
    if (vif.view_stable !== 1'b0) begin failures++; $display("FAIL ftol_stable: got %b, expected 0", vif.view_stable); end
    @(negedge clk);
    check_lit("ftol_pulse_1cyc", 3'b010, 1'b0, 1'b0);
    wait_change("to_left", 3'b011, n);
    tests++;
    if (n != TRANS * FLEN - 1) begin failures++; $display("FAIL ftol_duration: %0d cycles, expected %0d", n + 1, TRANS * FLEN); end
    press(0, 1, 8);
    wait_change("to_ltof", 3'b100, n);
    wait_change("to_fwd", 3'b001, n);

    // Conflict: both debounced on the same cycle cancel each other.
    press(1, 1, 8);
    repeat (2 * FLEN + 5) @(negedge clk);
    check_lit("conflict_fwd", 3'b001, 1'b0, 1'b1);
    press(1, 0, 8);
    wait_change("post_conflict_ftol", 3'b010, n);

    // Abort by enable during FtoL.
    vif.enable = 0;
    @(negedge clk);
    check_lit("enable_abort", 3'b001, 1'b1, 1'b1);
    vif.enable = 1;
    repeat (5) @(negedge clk);

    // Queued request during FtoR.
    press(0, 1, 8);
    wait_change("to_ftor", 3'b101, n);
    press(1, 0, 8);
    wait_change("to_right", 3'b110, n);
    wait_change("to_rtof", 3'b111, n);
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1 check_lit("async_reset", 3'b001, 1'b0, 1'b1);
    @(negedge clk);
    reset = 0;

    // Randomized phase.
    for (int seg = 0; seg < 300; seg++) begin
      vif.btn_left  = 1'($urandom_range(0, 1));
      vif.btn_right = 1'($urandom_range(0, 1));
      vif.enable    = ($urandom_range(0, 19) != 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    vif.enable = 1; vif.btn_left = 0; vif.btn_right = 0;
    repeat (3 * FLEN) @(negedge clk);
    run_cmp = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
